sa_addr_seq: RTL and testbench

//  Sequencer that drives addr_serial_num of the systolic-array SRAM address selector.

---
 rtl/sa_addr_seq.sv | 122 ++++++++++++
 tb/tb_sa_addr_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_addr_seq.sv
// Serial-index sequencer for the systolic-array SRAM address selector.
// Sweeps 0..LAST_SER per tile, supports stall, and flags aligned read data.
module sa_addr_seq #(
    parameter int SER_W    = 7,
    parameter int LAST_SER = 102,
    parameter int IDLE_SER = 127,
    parameter int SRAM_LAT = 1,
    parameter int TILE_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic              stall,
    output logic              busy,
    output logic [SER_W-1:0]  addr_serial_num,
    output logic [TILE_W-1:0] tile_idx,
    output logic              out_valid,
    output logic              tile_done,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Issue-to-array latency: selector register plus SRAM read latency.
    localparam int PIPE  = 1 + SRAM_LAT;
    localparam int CNT_W = $clog2(PIPE + 1);

    localparam logic [SER_W-1:0] LAST_V = SER_W'(LAST_SER);
    localparam logic [SER_W-1:0] IDLE_V = SER_W'(IDLE_SER);

    state_t            state, state_n;
    logic [SER_W-1:0]  ser_n;
    logic [TILE_W-1:0] tile_n;
    logic [TILE_W-1:0] ntiles_q, ntiles_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [PIPE-1:0]   vpipe;
    logic              issue;
    logic              last_beat;

    // Next-state, next-index and issue decode.
    always_comb begin
        state_n   = state;
        ser_n     = addr_serial_num;
        tile_n    = tile_idx;
        ntiles_n  = ntiles_q;
        cnt_n     = cnt_q;
        issue     = 1'b0;
        last_beat = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    ntiles_n = num_tiles;
                    tile_n   = '0;
                    if (num_tiles != '0) begin
                        state_n = RUN;
                        ser_n   = '0;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            RUN: begin
                if (!stall) begin
                    issue = 1'b1;
                    if (addr_serial_num != LAST_V) begin
                        ser_n = addr_serial_num + SER_W'(1);
                    end else begin
                        last_beat = 1'b1;
                        if (tile_idx != ntiles_q - TILE_W'(1)) begin
                            ser_n  = '0;
                            tile_n = tile_idx + TILE_W'(1);
                        end else begin
                            state_n = DRAIN;
                            ser_n   = IDLE_V;
                            cnt_n   = CNT_W'(PIPE - 1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, index and registered output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            addr_serial_num <= IDLE_V;
            tile_idx        <= '0;
            ntiles_q        <= '0;
            cnt_q           <= '0;
            vpipe           <= '0;
            busy            <= 1'b0;
            tile_done       <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_n;
            addr_serial_num <= ser_n;
            tile_idx        <= tile_n;
            ntiles_q        <= ntiles_n;
            cnt_q           <= cnt_n;
            vpipe           <= (vpipe << 1) | PIPE'(issue);
            busy            <= (state_n != IDLE);
            tile_done       <= last_beat;
            done            <= (state_n == DONE);
        end
    end

    assign out_valid = vpipe[PIPE-1];

endmodule

// File: tb/tb_sa_addr_seq.sv
// Directed bench for sa_addr_seq; cycle 0 is the cycle start is driven.
// Expected sequences are hand-derived for LAST_SER=102, SRAM_LAT=1.
module tb_sa_addr_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] num_tiles;
    logic       stall;
    logic       busy;
    logic [6:0] addr_serial_num;
    logic [7:0] tile_idx;
    logic       out_valid;
    logic       tile_done;
    logic       done;

    int tests = 0;
    int fails = 0;

    sa_addr_seq dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .num_tiles       (num_tiles),
        .stall           (stall),
        .busy            (busy),
        .addr_serial_num (addr_serial_num),
        .tile_idx        (tile_idx),
        .out_valid       (out_valid),
        .tile_done       (tile_done),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; num_tiles = 8'd0; stall = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        tests++;
        if ({busy, addr_serial_num, tile_idx, out_valid, tile_done, done}
            !== {1'b0, 7'd127, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset: busy=%0b idx=%0d tile=%0d ov=%0b td=%0b dn=%0b",
                     busy, addr_serial_num, tile_idx, out_valid, tile_done, done);
        end
    endtask

    task automatic test_single_tile();
        int bad = 0;
        int beats = 0;
        num_tiles = 8'd1; start = 1'b1;
        for (int c = 1; c <= 108; c++) begin
            logic [6:0] ei;
            step();
            start = 1'b0;
            ei = (c <= 103) ? 7'(c - 1) : 7'd127;
            if (out_valid) beats++;
            if (addr_serial_num !== ei || out_valid !== (c >= 3 && c <= 105) ||
                tile_done !== (c == 104) || done !== (c == 106) ||
                busy !== (c <= 106)) begin
                if (bad < 4)
                    $display("FAIL single c=%0d: idx=%0d/%0d ov=%0b td=%0b dn=%0b busy=%0b",
                             c, addr_serial_num, ei, out_valid, tile_done, done, busy);
                bad++;
            end
        end
        tests++;
        if (bad != 0) fails++;
        tests++;
        if (beats !== 103) begin
            fails++;
            $display("FAIL single_beats: got %0d want 103", beats);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        int beats = 0;
        int tdn = 0;
        num_tiles = 8'd3; start = 1'b1;
        for (int c = 1; c <= 314; c++) begin
            logic [6:0] ei;
            logic [7:0] et;
            step();
            start = 1'b0;
            ei = (c <= 309) ? 7'((c - 1) % 103) : 7'd127;
            et = (c <= 309) ? 8'((c - 1) / 103) : 8'd2;
            if (out_valid) beats++;
            if (tile_done) tdn++;
            if (addr_serial_num !== ei || tile_idx !== et ||
                out_valid !== (c >= 3 && c <= 311) ||
                tile_done !== (c == 104 || c == 207 || c == 310) ||
                done !== (c == 312) || busy !== (c <= 312)) begin
                if (bad < 4)
                    $display("FAIL b2b c=%0d: idx=%0d/%0d tile=%0d/%0d ov=%0b td=%0b dn=%0b",
                             c, addr_serial_num, ei, tile_idx, et, out_valid, tile_done, done);
                bad++;
            end
        end
        tests++;
        if (bad != 0) fails++;
        tests++;
        if (beats !== 309 || tdn !== 3) begin
            fails++;
            $display("FAIL b2b_counts: beats=%0d want 309 tile_done=%0d want 3", beats, tdn);
        end
    endtask

    task automatic test_stall();
        int bad = 0;
        int beats = 0;
        num_tiles = 8'd1; start = 1'b1;
        for (int c = 1; c <= 112; c++) begin
            logic [6:0] ei;
            logic       ev;
            step();
            start = 1'b0;
            if (c <= 51) ei = 7'(c - 1);
            else if (c <= 55) ei = 7'd50;
            else if (c <= 107) ei = 7'(c - 5);
            else ei = 7'd127;
            ev = (c >= 3 && c <= 52) || (c >= 57 && c <= 109);
            if (out_valid) beats++;
            if (addr_serial_num !== ei || out_valid !== ev ||
                tile_done !== (c == 108) || done !== (c == 110) ||
                busy !== (c <= 110)) begin
                if (bad < 4)
                    $display("FAIL stall c=%0d: idx=%0d/%0d ov=%0b/%0b td=%0b dn=%0b",
                             c, addr_serial_num, ei, out_valid, ev, tile_done, done);
                bad++;
            end
            stall = (c >= 51 && c <= 54);
        end
        stall = 1'b0;
        tests++;
        if (bad != 0) fails++;
        tests++;
        if (beats !== 103) begin
            fails++;
            $display("FAIL stall_beats: got %0d want 103", beats);
        end
    endtask

    task automatic test_start_ignored();
        int bad = 0;
        int dn = 0;
        num_tiles = 8'd1; start = 1'b1;
        for (int c = 1; c <= 112; c++) begin
            logic [6:0] ei;
            step();
            start = 1'b0;
            ei = (c <= 103) ? 7'(c - 1) : 7'd127;
            if (done) dn++;
            if (addr_serial_num !== ei || tile_idx !== 8'd0 ||
                out_valid !== (c >= 3 && c <= 105) ||
                busy !== (c <= 106)) begin
                if (bad < 4)
                    $display("FAIL start_ign c=%0d: idx=%0d/%0d busy=%0b ov=%0b",
                             c, addr_serial_num, ei, busy, out_valid);
                bad++;
            end
            if (c == 20) begin start = 1'b1; num_tiles = 8'd5; end
            if (c == 106) start = 1'b1;
        end
        tests++;
        if (bad != 0) fails++;
        tests++;
        if (dn !== 1) begin
            fails++;
            $display("FAIL start_ign_done: got %0d pulses want 1", dn);
        end
    endtask

    task automatic test_zero_tiles();
        num_tiles = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if ({done, busy, out_valid, addr_serial_num} !== {1'b1, 1'b1, 1'b0, 7'd127}) begin
            fails++;
            $display("FAIL zero_c1: dn=%0b busy=%0b ov=%0b idx=%0d want 1 1 0 127",
                     done, busy, out_valid, addr_serial_num);
        end
        step();
        tests++;
        if ({done, busy, out_valid, addr_serial_num} !== {1'b0, 1'b0, 1'b0, 7'd127}) begin
            fails++;
            $display("FAIL zero_c2: dn=%0b busy=%0b ov=%0b idx=%0d want 0 0 0 127",
                     done, busy, out_valid, addr_serial_num);
        end
    endtask

    task automatic test_mid_reset();
        int bad = 0;
        num_tiles = 8'd2; start = 1'b1;
        for (int c = 1; c <= 174; c++) begin
            step();
            start = 1'b0;
        end
        tests++;
        if (addr_serial_num !== 7'd70 || tile_idx !== 8'd1) begin
            fails++;
            $display("FAIL pre_reset: idx=%0d tile=%0d want 70 1", addr_serial_num, tile_idx);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if ({busy, addr_serial_num, tile_idx, out_valid, tile_done, done}
            !== {1'b0, 7'd127, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL mid_reset: busy=%0b idx=%0d tile=%0d ov=%0b td=%0b dn=%0b",
                     busy, addr_serial_num, tile_idx, out_valid, tile_done, done);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            if (done || busy || out_valid || addr_serial_num !== 7'd127) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL post_reset_quiet: %0d bad cycles want 0", bad);
        end
        bad = 0;
        num_tiles = 8'd1; start = 1'b1;
        for (int c = 1; c <= 107; c++) begin
            step();
            start = 1'b0;
            if (done !== (c == 106) || tile_done !== (c == 104) ||
                out_valid !== (c >= 3 && c <= 105)) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL rerun_after_reset: %0d bad cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_back_to_back();
        test_stall();
        test_start_ignored();
        test_zero_tiles();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
